// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, drives the instruction address and paces the datapath
// with one-hot five-phase strobes p1..p5. Optional single-step: FETCH_SEQUENCER_SINGLE_STEP_EN.
module fetch_sequencer #(
    parameter int unsigned           ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  halt_req,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
    input  logic                  step,
`endif
    output logic [ADDR_WIDTH-1:0] inst_addr,
    output logic [ADDR_WIDTH-1:0] pc_next_seq,
    output logic                  p1,
    output logic                  p2,
    output logic                  p3,
    output logic                  p4,
    output logic                  p5,
    output logic                  running
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHalted
    } state_e;

    localparam logic [4:0] PhaseNone  = 5'b00000;
    localparam logic [4:0] PhaseFirst = 5'b00001;

    state_e                state_q, state_d;
    logic [4:0]            phase_q, phase_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  halt_pending_q, halt_pending_d;
    logic                  step_mode_q, step_mode_d;
    logic                  end_of_inst;
    logic                  stop_after_inst;

    assign pc_next_seq = pc_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    assign end_of_inst = phase_q[4];
    // Single-step acts like a halt request that is already pending.
    assign stop_after_inst = halt_pending_q | halt_req | step_mode_q;

    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        pc_d           = pc_q;
        halt_pending_d = halt_pending_q;
        step_mode_d    = step_mode_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    phase_d = PhaseFirst;
                end
            end

            StRun: begin
                if (end_of_inst) begin
                    pc_d = branch_taken ? branch_target : pc_next_seq;
                    if (stop_after_inst) begin
                        state_d        = StHalted;
                        phase_d        = PhaseNone;
                        halt_pending_d = 1'b0;
                        step_mode_d    = 1'b0;
                    end else begin
                        phase_d = PhaseFirst;
                    end
                end else begin
                    // An empty phase register would otherwise stall RUN forever.
                    phase_d = (phase_q == PhaseNone) ? PhaseFirst : {phase_q[3:0], 1'b0};
                    if (halt_req) begin
                        halt_pending_d = 1'b1;
                    end
                end
            end

            StHalted: begin
                if (start) begin
                    state_d = StRun;
                    phase_d = PhaseFirst;
                end
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
                else if (step) begin
                    state_d     = StRun;
                    phase_d     = PhaseFirst;
                    step_mode_d = 1'b1;
                end
`endif
            end

            default: begin
                state_d        = StIdle;
                phase_d        = PhaseNone;
                halt_pending_d = 1'b0;
                step_mode_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= StIdle;
            phase_q        <= PhaseNone;
            pc_q           <= RESET_PC;
            halt_pending_q <= 1'b0;
            step_mode_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            pc_q           <= pc_d;
            halt_pending_q <= halt_pending_d;
            step_mode_q    <= step_mode_d;
        end
    end

    assign inst_addr            = pc_q;
    assign {p5, p4, p3, p2, p1} = phase_q;
    assign running              = (state_q == StRun);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: stimulus pushes per-cycle expected outputs,
// a negedge monitor pops and compares them.
module tb_fetch_sequencer;

    localparam logic [4:0] P0 = 5'b00000;
    localparam logic [4:0] P1 = 5'b00001;
    localparam logic [4:0] P2 = 5'b00010;
    localparam logic [4:0] P3 = 5'b00100;
    localparam logic [4:0] P4 = 5'b01000;
    localparam logic [4:0] P5 = 5'b10000;

    typedef struct packed {
        logic [4:0]  ph;
        logic        run;
        logic [15:0] addr;
        logic [15:0] nxt;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        start;
    logic        halt_req;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        step;
    logic [15:0] inst_addr;
    logic [15:0] pc_next_seq;
    logic        p1, p2, p3, p4, p5;
    logic        running;

    exp_t exp_q[$];
    int   total;
    int   bad;

    fetch_sequencer #(
        .ADDR_WIDTH(16),
        .RESET_PC  (16'h0000)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .halt_req     (halt_req),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
        .step         (step),
`endif
        .inst_addr    (inst_addr),
        .pc_next_seq  (pc_next_seq),
        .p1           (p1),
        .p2           (p2),
        .p3           (p3),
        .p4           (p4),
        .p5           (p5),
        .running      (running)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic push_exp(input logic [4:0] ph, input logic run, input logic [15:0] addr);
        exp_t e;
        e.ph   = ph;
        e.run  = run;
        e.addr = addr;
        e.nxt  = addr + 16'h0001;
        exp_q.push_back(e);
    endtask

    // Drive this cycle's inputs and record the outputs expected during this cycle.
    task automatic tick(input logic s, input logic h, input logic b, input logic st,
                        input logic [15:0] tgt, input logic [4:0] ph, input logic run,
                        input logic [15:0] addr);
        @(posedge clock);
        #1;
        start         = s;
        halt_req      = h;
        branch_taken  = b;
        step          = st;
        branch_target = tgt;
        push_exp(ph, run, addr);
    endtask

    task automatic inst(input logic [15:0] addr);
        tick(0, 0, 0, 0, 16'h0, P1, 1, addr);
        tick(0, 0, 0, 0, 16'h0, P2, 1, addr);
        tick(0, 0, 0, 0, 16'h0, P3, 1, addr);
        tick(0, 0, 0, 0, 16'h0, P4, 1, addr);
        tick(0, 0, 0, 0, 16'h0, P5, 1, addr);
    endtask

    // Monitor: every cycle with an outstanding expectation is compared.
    initial begin
        exp_t e;
        exp_t act;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e        = exp_q.pop_front();
                act.ph   = {p5, p4, p3, p2, p1};
                act.run  = running;
                act.addr = inst_addr;
                act.nxt  = pc_next_seq;
                total++;
                if (act !== e) begin
                    bad++;
                    $display("FAIL cycle_outputs #%0d at %0t: got ph=%b run=%b addr=%h nxt=%h, want ph=%b run=%b addr=%h nxt=%h",
                             total, $time, act.ph, act.run, act.addr, act.nxt,
                             e.ph, e.run, e.addr, e.nxt);
                end
            end
        end
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: got timeout, want stimulus completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        total         = 0;
        bad           = 0;
        reset         = 1'b0;
        start         = 1'b0;
        halt_req      = 1'b0;
        branch_taken  = 1'b0;
        step          = 1'b0;
        branch_target = 16'h0;

        // Reset state, then release; IDLE without start stays IDLE.
        @(posedge clock);
        tick(0, 0, 0, 0, 16'h0, P0, 0, 16'h0000);
        reset = 1'b1;
        tick(0, 0, 0, 0, 16'h0, P0, 0, 16'h0000);

        // Start: p1..p5 at 0, then next instruction at 1.
        tick(1, 0, 0, 0, 16'h0, P0, 0, 16'h0000);
        inst(16'h0000);

        // Branch in p3 ignored (start in RUN also ignored).
        tick(0, 0, 0, 0, 16'h0,    P1, 1, 16'h0001);
        tick(0, 0, 0, 0, 16'h0,    P2, 1, 16'h0001);
        tick(1, 0, 1, 0, 16'h1234, P3, 1, 16'h0001);
        tick(0, 0, 0, 0, 16'h0,    P4, 1, 16'h0001);
        tick(0, 0, 0, 0, 16'h0,    P5, 1, 16'h0001);

        // Branch in p5 taken.
        tick(0, 0, 0, 0, 16'h0,    P1, 1, 16'h0002);
        tick(0, 0, 0, 0, 16'h0,    P2, 1, 16'h0002);
        tick(0, 0, 0, 0, 16'h0,    P3, 1, 16'h0002);
        tick(0, 0, 0, 0, 16'h0,    P4, 1, 16'h0002);
        tick(0, 0, 1, 0, 16'h1234, P5, 1, 16'h0002);

        tick(0, 0, 0, 0, 16'h0,    P1, 1, 16'h1234);
        tick(0, 0, 0, 0, 16'h0,    P2, 1, 16'h1234);
        tick(0, 0, 0, 0, 16'h0,    P3, 1, 16'h1234);
        tick(0, 0, 0, 0, 16'h0,    P4, 1, 16'h1234);
        tick(0, 0, 1, 0, 16'h0005, P5, 1, 16'h1234);

        // halt_req pulsed in p2 at 0x0005: instruction completes, then HALTED at 0x0006.
        tick(0, 0, 0, 0, 16'h0, P1, 1, 16'h0005);
        tick(0, 1, 0, 0, 16'h0, P2, 1, 16'h0005);
        tick(0, 0, 0, 0, 16'h0, P3, 1, 16'h0005);
        tick(0, 0, 0, 0, 16'h0, P4, 1, 16'h0005);
        tick(0, 0, 0, 0, 16'h0, P5, 1, 16'h0005);
        tick(0, 0, 1, 0, 16'h9999, P0, 0, 16'h0006);
        tick(1, 0, 0, 0, 16'h0,    P0, 0, 16'h0006);

        // Halt and branch together in p5: target loaded, then HALTED.
        tick(0, 0, 0, 0, 16'h0,    P1, 1, 16'h0006);
        tick(0, 0, 0, 0, 16'h0,    P2, 1, 16'h0006);
        tick(0, 0, 0, 0, 16'h0,    P3, 1, 16'h0006);
        tick(0, 0, 0, 0, 16'h0,    P4, 1, 16'h0006);
        tick(0, 1, 1, 0, 16'hFFFF, P5, 1, 16'h0006);
        tick(1, 0, 0, 0, 16'h0,    P0, 0, 16'hFFFF);

        // PC wrap from 0xFFFF.
        inst(16'hFFFF);

        // Asynchronous reset mid-p3 aborts without PC update.
        tick(0, 0, 0, 0, 16'h0, P1, 1, 16'h0000);
        tick(0, 0, 0, 0, 16'h0, P2, 1, 16'h0000);
        @(posedge clock);
        #3;
        reset = 1'b0;
        push_exp(P0, 0, 16'h0000);
        tick(0, 0, 0, 0, 16'h0, P0, 0, 16'h0000);
        reset = 1'b1;
        tick(0, 0, 0, 0, 16'h0, P0, 0, 16'h0000);

        // start and halt_req together in IDLE: start wins; held halt_req latches in p1.
        tick(1, 1, 0, 0, 16'h0, P0, 0, 16'h0000);
        tick(0, 1, 0, 0, 16'h0, P1, 1, 16'h0000);
        tick(0, 0, 0, 0, 16'h0, P2, 1, 16'h0000);
        tick(0, 0, 0, 0, 16'h0, P3, 1, 16'h0000);
        tick(0, 0, 0, 0, 16'h0, P4, 1, 16'h0000);
        tick(0, 0, 0, 0, 16'h0, P5, 1, 16'h0000);
        tick(1, 0, 0, 0, 16'h0, P0, 0, 16'h0001);

        // Park HALTED at 0x0010.
        tick(0, 0, 0, 0, 16'h0,    P1, 1, 16'h0001);
        tick(0, 0, 0, 0, 16'h0,    P2, 1, 16'h0001);
        tick(0, 0, 0, 0, 16'h0,    P3, 1, 16'h0001);
        tick(0, 0, 0, 0, 16'h0,    P4, 1, 16'h0001);
        tick(0, 1, 1, 0, 16'h0010, P5, 1, 16'h0001);
        tick(0, 0, 0, 0, 16'h0,    P0, 0, 16'h0010);

`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
        // Single step from HALTED: one instruction, then back to HALTED.
        tick(0, 0, 0, 1, 16'h0, P0, 0, 16'h0010);
        inst(16'h0010);
        tick(0, 0, 0, 0, 16'h0, P0, 0, 16'h0011);
        tick(0, 0, 0, 0, 16'h0, P0, 0, 16'h0011);
`else
        tick(0, 0, 0, 0, 16'h0, P0, 0, 16'h0010);
        tick(0, 0, 0, 0, 16'h0, P0, 0, 16'h0010);
`endif

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(posedge clock);
        end
        @(posedge clock);
        if (exp_q.size() > 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Upstream stage of the instruction register.
- Owns the program counter and drives the instruction-memory address.
- Generates the one-hot five-phase strobes p1..p5 that pace the datapath. p2 is the instruction register's latch enable.
- Provides run/halt control: start, halt and branch redirect from the execute stage.

Parameters:
- ADDR_WIDTH, 16, width of program counter and instruction address.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  run request; sampled when in IDLE or HALTED.
- halt_req  in  1  stop request; latched any cycle while RUN.
- branch_taken  in  1  redirect PC; sampled only in the p5 cycle.
- branch_target  in  ADDR_WIDTH  redirect address, used with branch_taken.
- inst_addr  out  ADDR_WIDTH  instruction memory address (= pc).
- pc_next_seq  out  ADDR_WIDTH  pc+1, modulo 2^ADDR_WIDTH, combinational.
- p1, p2, p3, p4, p5  out  1 each  one-hot phase strobes; all 0 when not running.
- running  out  1  1 while in RUN.

Behaviour:
- Reset (reset=0, asynchronous):
  - State=IDLE, pc=RESET_PC, phase register cleared, halt_pending=0.
  - p1..p5=0, running=0, inst_addr=RESET_PC.
  - Reset asserted mid-instruction aborts the instruction immediately; no PC update occurs.
- States: IDLE, RUN, HALTED.
  - IDLE -> RUN when start=1. The next cycle is p1.
  - RUN: phase advances p1->p2->p3->p4->p5->p1, one per cycle. Exactly one strobe is high per cycle.
  - RUN -> HALTED at the end of the p5 cycle if halt_pending=1 or halt_req=1 in that cycle.
    - Phases go to 0; halt_pending is cleared.
    - The PC update for that instruction still happens.
  - HALTED -> RUN when start=1. Resumes at p1 with the current pc.
- Halt handling:
  - halt_req is never honoured mid-instruction; the current instruction always completes through p5.
  - halt_pending is set by halt_req=1 in any RUN cycle p1..p4.
- PC update occurs only on the clock edge ending p5:
  - pc <= branch_target if branch_taken=1, else pc+1.
  - pc+1 wraps from all-ones to 0, no flag.
  - branch_taken in cycles other than p5 is ignored.
- Fixed timing:
  - inst_addr equals pc and is stable from p1 through p5, so memory data is valid for the p2 latch.
  - Latency: start to the first p2 strobe is exactly 2 cycles (start cycle, p1 cycle, then p2).
- Simultaneous events:
  - start=1 while in RUN: ignored.
  - start and halt_req both high in IDLE: start wins. Halt is latched from the next RUN cycle if halt_req is still high.
  - halt_req and branch_taken both high in p5: branch target is loaded, then HALTED.

Optional Feature:
- Macro: FETCH_SEQUENCER_SINGLE_STEP_EN.
- When defined:
  - Adds input port step (1 bit).
  - In HALTED, step=1 (with start=0) executes exactly one instruction p1..p5, updates the PC, then returns to HALTED.
  - step is ignored in RUN and IDLE.
  - start has priority over step.
- When undefined: no step port; HALTED leaves only via start.

Test Plan:
- Reset release, start=1 for one cycle -> p1 high in cycle 1, p2 in cycle 2 … p5 in cycle 5, p1 again in cycle 6. inst_addr=0x0000 for cycles 1-5, then 0x0001.
- branch_taken=1 with branch_target=0x1234 during p5 -> next p1 shows inst_addr=0x1234. Same inputs asserted in p3 instead -> inst_addr=0x0001.
- halt_req pulsed during p2 of instruction at 0x0005 -> p3..p5 complete, then all strobes 0, running=0, inst_addr=0x0006. Start then resumes at p1 with 0x0006.
- PC=0xFFFF, no branch, end of p5 -> inst_addr=0x0000.
- reset driven low asynchronously during p3 -> strobes 0 immediately, inst_addr=RESET_PC, state IDLE. start needed to rerun.
- With FETCH_SEQUENCER_SINGLE_STEP_EN: HALTED at 0x0010, step pulse -> one p1..p5 sequence, then HALTED with inst_addr=0x0011.
